// File: rtl/rgb_breath_pkg.sv
// Shared palette definitions for the RGB breathing controller.
package rgb_breath_pkg;

    localparam int NUM_COLORS = 7;

    typedef logic [2:0] color_idx_t;

    localparam color_idx_t RED        = 3'd0;
    localparam color_idx_t ORANGE     = 3'd1;
    localparam color_idx_t YELLOW     = 3'd2;
    localparam color_idx_t GREEN      = 3'd3;
    localparam color_idx_t BLUE       = 3'd4;
    localparam color_idx_t PURPLE     = 3'd5;
    localparam color_idx_t WHITE      = 3'd6;
    localparam color_idx_t LAST_COLOR = WHITE;

    typedef struct packed {
        logic [15:0] r;
        logic [15:0] g;
        logic [15:0] b;
    } rgb_tgt_t;

    // Channel targets for a given full-scale value; orange green is 2/5 of full scale.
    function automatic rgb_tgt_t palette(input color_idx_t c, input logic [15:0] max_v);
        rgb_tgt_t   t;
        logic [15:0] two_fifths;
        two_fifths = 16'((32'(max_v) * 32'd2) / 32'd5);
        t = '0;
        case (c)
            RED:    t.r = max_v;
            ORANGE: begin t.r = max_v; t.g = two_fifths; end
            YELLOW: begin t.r = max_v; t.g = max_v; end
            GREEN:  t.g = max_v;
            BLUE:   t.b = max_v;
            PURPLE: begin t.r = max_v; t.b = max_v; end
            WHITE:  begin t.r = max_v; t.g = max_v; t.b = max_v; end
            default: t = '0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/rgb_breath_array_btn_debounce.sv
// Button synchroniser + debouncer producing a one-cycle press pulse.
// Latency: 2 sync flops plus DB_CYC stable cycles to the registered pulse.
// Backpressure: none; the raw button is sampled every cycle.
module btn_debounce #(
    parameter int DB_CYC = 1250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DB_CYC + 1);

    logic          sync_a;
    logic          sync_b;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            press  <= 1'b0;
            // cnt holds how many previous cycles in a row disagreed with level
            if (sync_b != level) begin
                if (cnt == CW'(DB_CYC - 1)) begin
                    level <= sync_b;
                    press <= sync_b;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/rgb_breath_array.sv
// Multi-LED RGB breathing controller: shared triangle brightness, palette colour, PWM.
// Latency: one clock from PWM counter to pin; duty changes land at the next PWM period.
// Backpressure: none; buttons and LED pins are free-running.
module rgb_breath_array
    import rgb_breath_pkg::*;
#(
    parameter int PWM_BITS      = 8,
    parameter int NUM_LED       = 2,
    parameter int NUM_SPEEDS    = 4,
    parameter int SPEED_RST     = 2,
    parameter int BASE_TICK_CYC = 490196,
    parameter int DB_CYC        = 1250000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_inc,
    input  logic                  btn_dec,
    input  logic                  hold,
    output logic [NUM_LED-1:0]    led_r,
    output logic [NUM_LED-1:0]    led_g,
    output logic [NUM_LED-1:0]    led_b,
    output logic [NUM_SPEEDS-1:0] led_speed
);
    localparam int SW = $clog2(NUM_SPEEDS);
    localparam int TW = $clog2(BASE_TICK_CYC + 1);
    localparam int PW = 2 * PWM_BITS + 1;
    localparam logic [PWM_BITS-1:0] MAX      = '1;
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((1 << PWM_BITS) - 2);
    localparam logic [15:0]         MAX16    = 16'((1 << PWM_BITS) - 1);
    localparam logic [SW-1:0]       SPD_TOP  = SW'(NUM_SPEEDS - 1);

    logic                inc_p, dec_p;
    logic [SW-1:0]       speed, speed_nxt;
    logic                speed_chg;
    logic [TW-1:0]       tick_cnt, tick_last;
    logic                step;
    logic [PWM_BITS-1:0] brightness;
    logic                dir_dn;
    color_idx_t          color_idx;
    logic [PWM_BITS-1:0] pwm_cnt;

    btn_debounce #(.DB_CYC(DB_CYC)) u_db_inc (.clk(clk), .rst(rst), .btn(btn_inc), .press(inc_p));
    btn_debounce #(.DB_CYC(DB_CYC)) u_db_dec (.clk(clk), .rst(rst), .btn(btn_dec), .press(dec_p));

    function automatic logic [TW-1:0] tick_last_of(input logic [SW-1:0] s);
        int unsigned len;
        len = int'(BASE_TICK_CYC) >> s;
        if (len == 0) len = 1;
        return TW'(len - 1);
    endfunction

    // Rounded scale: exact 0 at zero brightness, exact MAX at full brightness and target.
    function automatic logic [PWM_BITS-1:0] duty_of(input logic [PWM_BITS-1:0] b, input logic [15:0] t);
        logic [PW-1:0] p;
        p = PW'(b) * PW'(t) + PW'(MAX);
        return PWM_BITS'(p >> PWM_BITS);
    endfunction

    always_comb begin
        speed_nxt = speed;
        if (inc_p && !dec_p && speed != SPD_TOP)
            speed_nxt = speed + SW'(1);
        else if (dec_p && !inc_p && speed != '0)
            speed_nxt = speed - SW'(1);
    end

    assign speed_chg = (speed_nxt != speed);
    assign tick_last = tick_last_of(speed);
    assign step      = !hold && !speed_chg && (tick_cnt == tick_last);

    always_ff @(posedge clk) begin
        if (!rst) begin
            speed     <= SW'(SPEED_RST);
            led_speed <= NUM_SPEEDS'(1) << SPEED_RST;
            tick_cnt  <= '0;
        end else begin
            speed     <= speed_nxt;
            led_speed <= NUM_SPEEDS'(1) << speed_nxt;
            if (speed_chg)
                tick_cnt <= '0;
            else if (!hold)
                tick_cnt <= (tick_cnt == tick_last) ? '0 : tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            brightness <= '0;
            dir_dn     <= 1'b0;
            color_idx  <= RED;
        end else if (step) begin
            if (!dir_dn) begin
                brightness <= brightness + PWM_BITS'(1);
                if (brightness == MAX - PWM_BITS'(1)) dir_dn <= 1'b1;
            end else begin
                brightness <= brightness - PWM_BITS'(1);
                // Colour moves on at the trough so the change is invisible.
                if (brightness == PWM_BITS'(1)) begin
                    dir_dn    <= 1'b0;
                    color_idx <= (color_idx == LAST_COLOR) ? RED : color_idx + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) pwm_cnt <= '0;
        else      pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PWM_BITS'(1);
    end

    for (genvar i = 0; i < NUM_LED; i++) begin : g_led
        color_idx_t          c;
        rgb_tgt_t            tgt;
        logic [PWM_BITS-1:0] duty_r, duty_g, duty_b;
        logic                out_r, out_g, out_b;

        assign c   = color_idx_t'((32'(color_idx) + 32'(i)) % 32'(NUM_COLORS));
        assign tgt = palette(c, MAX16);

        always_ff @(posedge clk) begin
            if (!rst) begin
                duty_r <= '0;
                duty_g <= '0;
                duty_b <= '0;
                out_r  <= 1'b0;
                out_g  <= 1'b0;
                out_b  <= 1'b0;
            end else begin
                if (pwm_cnt == PWM_LAST) begin
                    duty_r <= duty_of(brightness, tgt.r);
                    duty_g <= duty_of(brightness, tgt.g);
                    duty_b <= duty_of(brightness, tgt.b);
                end
                out_r <= (pwm_cnt < duty_r);
                out_g <= (pwm_cnt < duty_g);
                out_b <= (pwm_cnt < duty_b);
            end
        end

        assign led_r[i] = out_r;
        assign led_g[i] = out_g;
        assign led_b[i] = out_b;
    end

endmodule

// File: tb/tb_rgb_breath_array.sv
// Bench for rgb_breath_array: directed scenarios plus random buttons/hold/reset vs a behavioural model.
module tb_rgb_breath_array;
    localparam int NL   = 2;
    localparam int NS   = 4;
    localparam int DB   = 4;
    localparam int MAXV = 15;
    localparam int BASE = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic btn_inc = 1'b0;
    logic btn_dec = 1'b0;
    logic hold = 1'b0;
    logic [NL-1:0] led_r, led_g, led_b;
    logic [NS-1:0] led_speed;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    rgb_breath_array #(
        .PWM_BITS(4), .NUM_LED(NL), .NUM_SPEEDS(NS), .SPEED_RST(2),
        .BASE_TICK_CYC(BASE), .DB_CYC(DB)
    ) dut (
        .clk(clk), .rst(rst), .btn_inc(btn_inc), .btn_dec(btn_dec), .hold(hold),
        .led_r(led_r), .led_g(led_g), .led_b(led_b), .led_speed(led_speed)
    );

    always #5 clk = ~clk;

    int PAL [7][3] = '{'{15, 0, 0}, '{15, 6, 0}, '{15, 15, 0}, '{0, 15, 0},
                       '{0, 0, 15}, '{15, 0, 15}, '{15, 15, 15}};

    // Model state: the breath is described purely by the number of steps taken.
    int m_speed, m_n, m_tick, m_p;
    int m_duty [NL][3];
    bit m_out [NL][3];
    bit m_s1 [2], m_s2 [2], m_lvl [2], m_press [2];
    bit win [2][DB];
    int fill [2];

    function automatic int tri_b(input int n);
        int pos;
        pos = n % (2 * MAXV);
        return (pos <= MAXV) ? pos : 2 * MAXV - pos;
    endfunction

    function automatic int color_of(input int n);
        return (n / (2 * MAXV)) % 7;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, want);
        end
    endtask

    always @(posedge clk) begin : model
        int b, c, len, spd_pre;
        bit chg, raw, newp, alld;
        if (!rst) begin
            m_speed = 2; m_n = 0; m_tick = 0; m_p = 0;
            for (int i = 0; i < NL; i++)
                for (int ch = 0; ch < 3; ch++) begin
                    m_duty[i][ch] = 0;
                    m_out[i][ch]  = 1'b0;
                end
            for (int k = 0; k < 2; k++) begin
                m_s1[k] = 0; m_s2[k] = 0; m_lvl[k] = 0; m_press[k] = 0; fill[k] = 0;
                for (int j = 0; j < DB; j++) win[k][j] = 0;
            end
        end else begin
            b = tri_b(m_n);
            c = color_of(m_n);
            for (int i = 0; i < NL; i++)
                for (int ch = 0; ch < 3; ch++) begin
                    m_out[i][ch] = (m_p < m_duty[i][ch]);
                    if (m_p == MAXV - 1)
                        m_duty[i][ch] = (b * PAL[(c + i) % 7][ch] + MAXV) >> 4;
                end
            spd_pre = m_speed;
            chg = 0;
            if (m_press[0] && !m_press[1] && m_speed < NS - 1) begin m_speed++; chg = 1; end
            else if (m_press[1] && !m_press[0] && m_speed > 0) begin m_speed--; chg = 1; end
            len = BASE >> spd_pre;
            if (len < 1) len = 1;
            if (chg) m_tick = 0;
            else if (!hold) begin
                if (m_tick == len - 1) begin m_tick = 0; m_n++; end
                else m_tick++;
            end
            for (int k = 0; k < 2; k++) begin
                raw = (k == 0) ? btn_inc : btn_dec;
                newp = 0;
                for (int j = DB - 1; j > 0; j--) win[k][j] = win[k][j-1];
                win[k][0] = m_s2[k];
                if (fill[k] < DB) fill[k]++;
                if (fill[k] == DB) begin
                    alld = 1;
                    for (int j = 0; j < DB; j++) if (win[k][j] == m_lvl[k]) alld = 0;
                    if (alld) begin m_lvl[k] = m_s2[k]; newp = m_s2[k]; end
                end
                m_s2[k] = m_s1[k];
                m_s1[k] = raw;
                m_press[k] = newp;
            end
            m_p = (m_p + 1) % MAXV;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [NL-1:0] er, eg, eb;
            for (int i = 0; i < NL; i++) begin
                er[i] = m_out[i][0];
                eg[i] = m_out[i][1];
                eb[i] = m_out[i][2];
            end
            chk("model_outputs", 32'({led_r, led_g, led_b, led_speed}),
                32'({er, eg, eb, 4'(1 << m_speed)}));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); @(negedge clk); end
    endtask

    task automatic press(input bit inc, input bit dec, input int hi);
        btn_inc = inc; btn_dec = dec;
        repeat (hi) @(posedge clk);
        #1; btn_inc = 0; btn_dec = 0;
        repeat (12) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int cr0, cg0, cg1, dur;
        chk_en = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_speed", 32'(led_speed), 32'b0100);
        chk("reset_leds", 32'({led_r, led_g, led_b}), 32'd0);
        rst = 1'b1;
        for (int k = 0; k < MAXV; k++) begin
            cyc(1);
            chk("first_period_dark", 32'({led_r, led_g, led_b}), 32'd0);
        end
        // Freeze at the peak and measure one PWM period of full-scale red.
        repeat (46) @(posedge clk);
        #1 hold = 1'b1;
        repeat (14) @(posedge clk);
        cr0 = 0; cg0 = 0; cg1 = 0;
        for (int k = 0; k < MAXV; k++) begin
            cyc(1);
            cr0 += int'(led_r[0]); cg0 += int'(led_g[0]); cg1 += int'(led_g[1]);
        end
        chk("hold_full_red_hi", cr0, 15);
        chk("hold_full_green_lo", cg0, 0);
        chk("hold_orange_green_pwm", cg1, 6);
        hold = 1'b0;
        cyc(5);
        rst = 1'b0;
        cyc(1);
        chk("midrun_reset_leds", 32'({led_r, led_g, led_b}), 32'd0);
        chk("midrun_reset_speed", 32'(led_speed), 32'b0100);
        rst = 1'b1;
        cyc(60);
        chk("model_peak_brightness", tri_b(m_n), 15);
        cyc(30);
        cr0 = 0; cg0 = 0; cg1 = 0;
        for (int k = 0; k < MAXV; k++) begin
            cyc(1);
            cr0 += int'(led_r[0]); cg0 += int'(led_g[0]); cg1 += int'(led_g[1]);
        end
        chk("half_red_hi_cycles", cr0, 8);
        chk("half_red_green_lo", cg0, 0);
        chk("half_orange_green", cg1, 3);
        cyc(15);
        chk("model_trough_brightness", tri_b(m_n), 0);
        chk("model_color_after_breath", color_of(m_n), 1);

        for (int k = 0; k < 3; k++) begin
            press(1, 0, 3);
            chk("glitch_ignored", 32'(led_speed), 32'b0100);
        end
        press(1, 0, 6);
        chk("inc_press", 32'(led_speed), 32'b1000);
        press(1, 0, 8);
        chk("inc_saturate", 32'(led_speed), 32'b1000);
        press(1, 1, 8);
        chk("both_ignored", 32'(led_speed), 32'b1000);
        press(0, 1, 8);
        chk("dec_1", 32'(led_speed), 32'b0100);
        press(0, 1, 8);
        chk("dec_2", 32'(led_speed), 32'b0010);
        press(0, 1, 8);
        chk("dec_3", 32'(led_speed), 32'b0001);
        press(0, 1, 8);
        chk("dec_saturate", 32'(led_speed), 32'b0001);
        rst = 1'b0;
        cyc(1);
        chk("reset_after_dec_speed", 32'(led_speed), 32'b0100);
        chk("reset_after_dec_leds", 32'({led_r, led_g, led_b}), 32'd0);
        rst = 1'b1;

        for (int it = 0; it < 2000; it++) begin
            dur = $urandom_range(1, 8);
            btn_inc = ($urandom_range(0, 2) == 0);
            btn_dec = ($urandom_range(0, 3) == 0);
            hold    = ($urandom_range(0, 3) == 0);
            rst     = ($urandom_range(0, 149) != 0);
            repeat (dur) begin
                @(posedge clk);
                #1 rst = 1'b1;
            end
        end
        btn_inc = 0; btn_dec = 0; hold = 0;
        cyc(40);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
